// File: rtl/seq_div_pkg.sv
// Shared types and constants for the sequential shift-subtract divider.
package seq_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  // Quotient reported on divide-by-zero; sliced to WIDTH by the user (WIDTH <= 64).
  localparam logic [63:0] DBZ_QUOT = '1;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >>> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/seq_div_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract the divisor.
module div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] partial_rem,
  input  logic             dividend_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] next_rem,
  output logic             qbit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // The extra top bit of trial is the borrow: set means the divisor did not fit.
  always_comb begin
    shifted  = {partial_rem, dividend_msb};
    trial    = shifted - {1'b0, divisor};
    qbit     = ~trial[WIDTH];
    next_rem = qbit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/seq_div.sv
// Multi-cycle signed/unsigned divider producing one quotient bit per clock with a start/valid handshake.
module seq_div
  import seq_div_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] rem,
  output logic             dbz
);

  localparam int               CNT_W = clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] prem;
  logic [WIDTH-1:0] dsr;
  logic             neg_q;
  logic             neg_r;
  logic             zdiv;
  logic [WIDTH-1:0] prem_nxt;
  logic             qbit;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
    logic signed [WIDTH-1:0] sv;
    sv = v;
    return (sgn && sv < 0) ? WIDTH'(-sv) : v;
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? WIDTH'(-v) : v;
  endfunction

  div_step #(.WIDTH(WIDTH)) u_step (
    .partial_rem  (prem),
    .dividend_msb (dvd[WIDTH-1]),
    .divisor      (dsr),
    .next_rem     (prem_nxt),
    .qbit         (qbit)
  );

  assign busy = (state != IDLE);

  // dvd doubles as the quotient shift register; on divide-by-zero it keeps the raw dividend.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      valid <= 1'b0;
      out   <= '0;
      rem   <= '0;
      dbz   <= 1'b0;
    end else begin
      valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            if (in2 == '0) begin
              dvd   <= in1;
              zdiv  <= 1'b1;
              state <= FIX;
            end else begin
              dvd   <= magnitude(in1, is_signed);
              dsr   <= magnitude(in2, is_signed);
              neg_q <= is_signed & (in1[WIDTH-1] ^ in2[WIDTH-1]);
              neg_r <= is_signed & in1[WIDTH-1];
              prem  <= '0;
              zdiv  <= 1'b0;
              cnt   <= '0;
              state <= CALC;
            end
          end
        end
        CALC: begin
          prem <= prem_nxt;
          dvd  <= {dvd[WIDTH-2:0], qbit};
          if (cnt == LAST) begin
            cnt   <= '0;
            state <= FIX;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        FIX: begin
          if (zdiv) begin
            out <= DBZ_QUOT[WIDTH-1:0];
            rem <= dvd;
            dbz <= 1'b1;
          end else begin
            out <= apply_sign(dvd, neg_q);
            rem <= apply_sign(prem, neg_r);
            dbz <= 1'b0;
          end
          valid <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_div.sv
// Directed bench for seq_div at WIDTH=8 with hand-computed quotient/remainder vectors.
module tb_seq_div;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             busy;
  logic             valid;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] rem;
  logic             dbz;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  seq_div #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .is_signed (is_signed),
    .in1       (in1),
    .in2       (in2),
    .busy      (busy),
    .valid     (valid),
    .out       (out),
    .rem       (rem),
    .dbz       (dbz)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called from a negedge; the following posedge captures the operands.
  task automatic launch(input logic sgn, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    start     = 1'b1;
    is_signed = sgn;
    in1       = a;
    in2       = b;
    @(posedge clk);
    #1;
    start     = 1'b0;
    is_signed = ~sgn;
    in1       = 8'hA5;
    in2       = 8'h00;
  endtask

  // Waits (bounded) for valid; returns positioned at the negedge where valid is seen.
  task automatic wait_result(input string tag, input int exp_lat, input logic [WIDTH-1:0] eq,
                             input logic [WIDTH-1:0] er, input logic ed);
    int n      = 0;
    int busy_n = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (valid) break;
      if (busy) busy_n++;
    end
    check({tag, " latency"}, n, exp_lat);
    check({tag, " busy"}, busy_n, exp_lat - 1);
    check({tag, " busy@valid"}, busy, 1'b0);
    check({tag, " out"}, out, eq);
    check({tag, " rem"}, rem, er);
    check({tag, " dbz"}, dbz, ed);
  endtask

  task automatic check_pulse_end(input string tag);
    @(negedge clk);
    check({tag, " valid pulse"}, valid, 1'b0);
  endtask

  initial begin
    int vcount;
    rst       = 1'b1;
    start     = 1'b0;
    is_signed = 1'b0;
    in1       = '0;
    in2       = '0;
    repeat (3) @(negedge clk);
    check("reset busy", busy, 1'b0);
    check("reset valid", valid, 1'b0);
    check("reset out", out, 8'h00);
    check("reset rem", rem, 8'h00);
    check("reset dbz", dbz, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    launch(1'b0, 8'd100, 8'd7);
    wait_result("u100/7", 10, 8'd14, 8'd2, 1'b0);
    check_pulse_end("u100/7");

    launch(1'b1, 8'hF9, 8'h02);
    wait_result("s-7/2", 10, 8'hFD, 8'hFF, 1'b0);
    check_pulse_end("s-7/2");

    launch(1'b1, 8'h07, 8'hFE);
    wait_result("s7/-2", 10, 8'hFD, 8'h01, 1'b0);
    check_pulse_end("s7/-2");

    launch(1'b0, 8'd55, 8'd0);
    wait_result("u55/0", 2, 8'hFF, 8'd55, 1'b1);
    check_pulse_end("u55/0");

    launch(1'b0, 8'd10, 8'd3);
    wait_result("u10/3", 10, 8'd3, 8'd1, 1'b0);
    check_pulse_end("u10/3");

    launch(1'b1, 8'h80, 8'hFF);
    wait_result("s-128/-1", 10, 8'h80, 8'h00, 1'b0);
    check_pulse_end("s-128/-1");

    launch(1'b0, 8'h80, 8'hFF);
    wait_result("u128/255", 10, 8'h00, 8'h80, 1'b0);
    check_pulse_end("u128/255");

    launch(1'b1, 8'hC8, 8'h00);
    wait_result("s-56/0", 2, 8'hFF, 8'hC8, 1'b1);
    check_pulse_end("s-56/0");

    // start during CALC with other operands must be ignored
    launch(1'b0, 8'd100, 8'd7);
    repeat (3) @(negedge clk);
    start = 1'b1;
    in1   = 8'd200;
    in2   = 8'd3;
    @(negedge clk);
    start = 1'b0;
    wait_result("ignored start", 6, 8'd14, 8'd2, 1'b0);
    check_pulse_end("ignored start");

    // back-to-back: new start in the valid cycle
    launch(1'b0, 8'd200, 8'd9);
    wait_result("b2b first", 10, 8'd22, 8'd2, 1'b0);
    launch(1'b1, 8'hEC, 8'h03);
    wait_result("b2b second", 10, 8'hFA, 8'hFE, 1'b0);
    check_pulse_end("b2b second");

    // reset sampled at edge 4 of a division
    launch(1'b0, 8'd50, 8'd3);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort busy", busy, 1'b0);
    check("abort valid", valid, 1'b0);
    check("abort out", out, 8'h00);
    check("abort rem", rem, 8'h00);
    check("abort dbz", dbz, 1'b0);
    vcount = 0;
    repeat (15) begin
      @(negedge clk);
      if (valid) vcount++;
    end
    check("abort no valid", vcount, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
